// File: rtl/sad_sequencer_pkg.sv
// sad_sequencer_pkg
//   Shared declarations for the SAD search sequencer:
//   - state_t       : sequencer FSM states
//   - HALF_OFFSET   : byte offset of read port B relative to port A
//   - WIN_ROWS      : number of window rows preloaded before a scan
//   - SAD_VALID_ROW : first frame row at which a full window SAD is available
//   - grid_addr()   : base + row*stride + 4*col, modulo 2^32
package sad_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_WIN = 3'd1,
    SCAN     = 3'd2,
    DRAIN    = 3'd3,
    READ_MIN = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam logic [31:0] HALF_OFFSET   = 32'd256;
  localparam int          WIN_ROWS      = 4;
  localparam int          SAD_VALID_ROW = 3;

  // Word-aligned frame address of (row, col); wraps naturally at 32 bits.
  function automatic logic [31:0] grid_addr(input logic [31:0] base,
                                            input logic [31:0] row,
                                            input logic [31:0] col,
                                            input logic [31:0] stride);
    return base + (row * stride) + (col << 2);
  endfunction

endpackage

// File: rtl/sad_sequencer_if.sv
// sad_sequencer_if
//   Groups the sequencer's command, memory-read and datapath-strobe signals.
//   master : search requester (drives start/win_base/frame_base)
//   slave  : the sequencer (drives read addresses, strobes and status)
//   With SAD_SEQ_PERF_CNT_EN defined, perf_cycles (busy cycle count) is added.
interface sad_sequencer_if;
  logic        start;
  logic [31:0] win_base;
  logic [31:0] frame_base;
  logic [31:0] mem_addr_A;
  logic [31:0] mem_addr_B;
  logic        mem_rd;
  logic        window_shift;
  logic        frame_shift;
  logic        min_in;
  logic        load_min;
  logic [31:0] tag_addr;
  logic        min_clr;
  logic        busy;
  logic        done;
`ifdef SAD_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  modport master (
    output start, win_base, frame_base,
    input  mem_addr_A, mem_addr_B, mem_rd,
    input  window_shift, frame_shift, min_in, load_min,
    input  tag_addr, min_clr, busy, done
`ifdef SAD_SEQ_PERF_CNT_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  start, win_base, frame_base,
    output mem_addr_A, mem_addr_B, mem_rd,
    output window_shift, frame_shift, min_in, load_min,
    output tag_addr, min_clr, busy, done
`ifdef SAD_SEQ_PERF_CNT_EN
    , output perf_cycles
`endif
  );
endinterface

// File: rtl/sad_addr_gen.sv
// sad_addr_gen
//   Read-address generator. Holds the window row counter k and the scan
//   counters r (inner, rows) and c (outer, columns). Each counter points at
//   the NEXT read to issue and wraps to zero after its last read, so all
//   counters are back at zero once a search has issued every read.
//   Ports: clk, rst_n (async active-low), clr (idle clear), win_step /
//   scan_step (advance after issuing), win_base / frame_base (byte bases),
//   win_addr / scan_addr (address of the read to issue), win_wrap /
//   scan_wrap (counter back at zero), row_valid (current row >= SAD_VALID_ROW).
module sad_addr_gen
  import sad_sequencer_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int STRIDE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        win_step,
  input  logic        scan_step,
  input  logic [31:0] win_base,
  input  logic [31:0] frame_base,
  output logic [31:0] win_addr,
  output logic [31:0] scan_addr,
  output logic        win_wrap,
  output logic        scan_wrap,
  output logic        row_valid
);
  localparam int KW = $clog2(WIN_ROWS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [KW-1:0] k_r;
  logic [RW-1:0] r_r;
  logic [CW-1:0] c_r;

  // Window row counter: 0..WIN_ROWS-1, then wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r <= {KW{1'b0}};
    end else if (win_step) begin
      k_r <= (k_r == KW'(WIN_ROWS - 1)) ? {KW{1'b0}} : k_r + KW'(1);
    end else if (clr) begin
      k_r <= {KW{1'b0}};
    end else begin
      k_r <= k_r;
    end
  end

  // Scan counters: row inner, column outer; both wrap after the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= {RW{1'b0}};
      c_r <= {CW{1'b0}};
    end else if (scan_step) begin
      if (r_r == RW'(ROWS - 1)) begin
        r_r <= {RW{1'b0}};
        c_r <= (c_r == CW'(COLS - 1)) ? {CW{1'b0}} : c_r + CW'(1);
      end else begin
        r_r <= r_r + RW'(1);
        c_r <= c_r;
      end
    end else if (clr) begin
      r_r <= {RW{1'b0}};
      c_r <= {CW{1'b0}};
    end else begin
      r_r <= r_r;
      c_r <= c_r;
    end
  end

  // Address arithmetic for the read about to be issued.
  always_comb begin
    win_addr  = win_base + (32'(k_r) * 32'(STRIDE));
    scan_addr = grid_addr(frame_base, 32'(r_r), 32'(c_r), 32'(STRIDE));
    win_wrap  = (k_r == {KW{1'b0}});
    scan_wrap = (r_r == {RW{1'b0}}) && (c_r == {CW{1'b0}});
    row_valid = (32'(r_r) >= 32'(SAD_VALID_ROW));
  end

endmodule

// File: rtl/sad_sequencer.sv
// sad_sequencer
//   Sequences one SAD block search: loads WIN_ROWS window rows, scans the
//   frame (ROWS rows x COLS word columns), drains the read pipeline, reads
//   back the minimum and its tag, then signals done.
//   Ports: Clk, Reset (async active-low), bus (sad_sequencer_if.slave):
//   start/win_base/frame_base in; mem_addr_A/mem_addr_B/mem_rd read issue;
//   window_shift/frame_shift/min_in/load_min/tag_addr/min_clr datapath
//   strobes; busy/done status.
//   Optional feature macro: SAD_SEQ_PERF_CNT_EN adds bus.perf_cycles.
//   All outputs are registered; the combinational block decides what the
//   NEXT cycle presents, so a read is visible in the cycle after the
//   decision and its strobe one cycle later (one-cycle memory latency).
module sad_sequencer
  import sad_sequencer_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int STRIDE = 64
) (
  input  logic           Clk,
  input  logic           Reset,
  sad_sequencer_if.slave bus
);
  localparam logic [31:0] TAG_BACK = 32'(SAD_VALID_ROW * STRIDE);

  state_t      state_r, state_s;
  logic        rm_phase_r, rm_phase_s;
  logic        win_step_s, scan_step_s, clr_s;
  logic [31:0] win_addr_s, scan_addr_s;
  logic        win_wrap_s, scan_wrap_s, row_valid_s;

  logic        rd_s, win_rd_s, scan_rd_s, valid_row_s;
  logic [31:0] rd_addr_s;
  logic        load_min_s, min_clr_s, busy_s, done_s;

  logic        mem_rd_r, win_rd_r, scan_rd_r, valid_row_r;
  logic [31:0] addr_a_r, addr_b_r, tag_r;
  logic        window_shift_r, frame_shift_r, min_in_r;
  logic        load_min_r, min_clr_r, busy_r, done_r;

  assign clr_s = (state_r == IDLE);

  sad_addr_gen #(.ROWS(ROWS), .COLS(COLS), .STRIDE(STRIDE)) u_addr_gen (
    .clk        (Clk),
    .rst_n      (Reset),
    .clr        (clr_s),
    .win_step   (win_step_s),
    .scan_step  (scan_step_s),
    .win_base   (bus.win_base),
    .frame_base (bus.frame_base),
    .win_addr   (win_addr_s),
    .scan_addr  (scan_addr_s),
    .win_wrap   (win_wrap_s),
    .scan_wrap  (scan_wrap_s),
    .row_valid  (row_valid_s)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      rm_phase_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      rm_phase_r <= rm_phase_s;
    end
  end

  // Next state plus the read/strobe/status values for the next cycle.
  always_comb begin
    state_s     = state_r;
    rm_phase_s  = 1'b0;
    win_step_s  = 1'b0;
    scan_step_s = 1'b0;
    rd_s        = 1'b0;
    win_rd_s    = 1'b0;
    scan_rd_s   = 1'b0;
    valid_row_s = 1'b0;
    rd_addr_s   = 32'd0;
    load_min_s  = 1'b0;
    min_clr_s   = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s    = LOAD_WIN;
          rd_s       = 1'b1;
          win_rd_s   = 1'b1;
          rd_addr_s  = win_addr_s;
          win_step_s = 1'b1;
          min_clr_s  = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_WIN: begin
        busy_s = 1'b1;
        rd_s   = 1'b1;
        // k wraps to zero once all window rows have been issued.
        if (!win_wrap_s) begin
          win_rd_s   = 1'b1;
          rd_addr_s  = win_addr_s;
          win_step_s = 1'b1;
        end else begin
          state_s     = SCAN;
          scan_rd_s   = 1'b1;
          rd_addr_s   = scan_addr_s;
          valid_row_s = row_valid_s;
          scan_step_s = 1'b1;
        end
      end
      SCAN: begin
        busy_s = 1'b1;
        // r/c back at zero means the final scan read is on the bus now.
        if (scan_wrap_s) begin
          state_s = DRAIN;
        end else begin
          rd_s        = 1'b1;
          scan_rd_s   = 1'b1;
          rd_addr_s   = scan_addr_s;
          valid_row_s = row_valid_s;
          scan_step_s = 1'b1;
        end
      end
      DRAIN: begin
        busy_s     = 1'b1;
        state_s    = READ_MIN;
        load_min_s = 1'b1;
      end
      READ_MIN: begin
        busy_s = 1'b1;
        // Phase 0 shows the minimum (load_min=1); phase 1 the tag.
        if (!rm_phase_r) begin
          rm_phase_s = 1'b1;
        end else begin
          state_s = FIN;
          done_s  = 1'b1;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Read issue and status registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mem_rd_r    <= 1'b0;
      addr_a_r    <= 32'd0;
      addr_b_r    <= 32'd0;
      win_rd_r    <= 1'b0;
      scan_rd_r   <= 1'b0;
      valid_row_r <= 1'b0;
      load_min_r  <= 1'b0;
      min_clr_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      mem_rd_r    <= rd_s;
      addr_a_r    <= rd_addr_s;
      addr_b_r    <= rd_s ? (rd_addr_s + HALF_OFFSET) : 32'd0;
      win_rd_r    <= win_rd_s;
      scan_rd_r   <= scan_rd_s;
      valid_row_r <= valid_row_s;
      load_min_r  <= load_min_s;
      min_clr_r   <= min_clr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // Strobe pipeline: data returns one cycle after each read issue.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      window_shift_r <= 1'b0;
      frame_shift_r  <= 1'b0;
      min_in_r       <= 1'b0;
      tag_r          <= 32'd0;
    end else begin
      window_shift_r <= win_rd_r;
      frame_shift_r  <= scan_rd_r;
      min_in_r       <= scan_rd_r & valid_row_r;
      // Tag names the top row of the candidate block just completed.
      tag_r          <= (scan_rd_r & valid_row_r) ? (addr_a_r - TAG_BACK) : 32'd0;
    end
  end

  assign bus.mem_rd       = mem_rd_r;
  assign bus.mem_addr_A   = addr_a_r;
  assign bus.mem_addr_B   = addr_b_r;
  assign bus.window_shift = window_shift_r;
  assign bus.frame_shift  = frame_shift_r;
  assign bus.min_in       = min_in_r;
  assign bus.load_min     = load_min_r;
  assign bus.tag_addr     = tag_r;
  assign bus.min_clr      = min_clr_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

`ifdef SAD_SEQ_PERF_CNT_EN
  logic [31:0] perf_r;

  // Busy-cycle counter: the accepting start cycle counts as the first.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      perf_r <= 32'd0;
    end else if ((state_r == IDLE) && bus.start) begin
      perf_r <= 32'd1;
    end else if (busy_r) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.perf_cycles = perf_r;
`endif

endmodule

// File: tb/tb_sad_sequencer.sv
// tb_sad_sequencer
//   Two sequencer instances (4x1 and 5x2, stride 64) driven from task-based
//   scenarios; every cycle is compared against a cycle-indexed reference
//   model computed directly from the read/strobe timing rules.
module tb_sad_sequencer;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sad_sequencer_if if_a ();
  sad_sequencer_if if_b ();

  sad_sequencer #(.ROWS(4), .COLS(1), .STRIDE(64)) dut_a (.Clk(Clk), .Reset(Reset), .bus(if_a));
  sad_sequencer #(.ROWS(5), .COLS(2), .STRIDE(64)) dut_b (.Clk(Clk), .Reset(Reset), .bus(if_b));

  typedef struct packed {
    logic        rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        ws;
    logic        fs;
    logic        mi;
    logic        lm;
    logic [31:0] tag;
    logic        mc;
    logic        busy;
    logic        done;
  } snap_t;

  snap_t snap_a, snap_b;
  assign snap_a = {if_a.mem_rd, if_a.mem_addr_A, if_a.mem_addr_B, if_a.window_shift,
                   if_a.frame_shift, if_a.min_in, if_a.load_min, if_a.tag_addr,
                   if_a.min_clr, if_a.busy, if_a.done};
  assign snap_b = {if_b.mem_rd, if_b.mem_addr_A, if_b.mem_addr_B, if_b.window_shift,
                   if_b.frame_shift, if_b.min_in, if_b.load_min, if_b.tag_addr,
                   if_b.min_clr, if_b.busy, if_b.done};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: expected outputs t cycles after the start cycle (t=0).
  // Timeline: 4 window reads, rows*cols frame reads, 1 drain, 2 readout, fin.
  function automatic snap_t expect_at(int t, int rows, int cols, logic [31:0] wb, logic [31:0] fb);
    snap_t e;
    int rc;
    int j;
    logic [31:0] ad;
    e  = '0;
    rc = rows * cols;
    if (t >= 1 && t <= 4 + rc) begin
      j = t - 1;
      if (j < 4) ad = wb + 32'(j * 64);
      else ad = fb + 32'(((j - 4) % rows) * 64 + 4 * ((j - 4) / rows));
      e.rd = 1'b1;
      e.a  = ad;
      e.b  = ad + 32'd256;
    end
    e.ws = (t >= 2 && t <= 5);
    if (t >= 6 && t <= 5 + rc) begin
      j    = t - 6;
      e.fs = 1'b1;
      if (j % rows >= 3) begin
        e.mi  = 1'b1;
        e.tag = fb + 32'((j % rows) * 64 + 4 * (j / rows)) - 32'd192;
      end
    end
    e.lm   = (t == 6 + rc);
    e.mc   = (t == 1);
    e.busy = (t >= 1 && t <= 8 + rc);
    e.done = (t == 8 + rc);
    return e;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [31:0] wb, input logic [31:0] fb);
    if (sel) begin
      if_b.start = st; if_b.win_base = wb; if_b.frame_base = fb;
    end else begin
      if_a.start = st; if_a.win_base = wb; if_a.frame_base = fb;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    n_tests++;
    if (snap_a !== '0) begin n_fail++; $display("FAIL reset_a got %h expected 0", snap_a); end
    n_tests++;
    if (snap_b !== '0) begin n_fail++; $display("FAIL reset_b got %h expected 0", snap_b); end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_single_column();
    snap_t o, e;
    int ws_n = 0, fs_n = 0, mi_n = 0, done_t = -1;
    logic [31:0] tag0 = 32'd0;
    drive(1'b0, 1'b1, 32'h100, 32'h400);
    tick();
    drive(1'b0, 1'b0, 32'h100, 32'h400);
    for (int t = 1; t <= 14; t++) begin
      o = snap_a;
      e = expect_at(t, 4, 1, 32'h100, 32'h400);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL single t=%0d got %h expected %h", t, o, e); end
      if (o.ws) ws_n++;
      if (o.fs) fs_n++;
      if (o.mi) begin mi_n++; tag0 = o.tag; end
      if (o.done && done_t < 0) done_t = t;
      tick();
    end
    n_tests++;
    if (ws_n != 4 || fs_n != 4 || mi_n != 1) begin
      n_fail++; $display("FAIL single_counts ws=%0d fs=%0d mi=%0d expected 4 4 1", ws_n, fs_n, mi_n);
    end
    n_tests++;
    if (tag0 !== 32'h400) begin n_fail++; $display("FAIL single_tag got %h expected 400", tag0); end
    // done lands in the 13th cycle counting the start cycle as the first.
    n_tests++;
    if (done_t != 12) begin n_fail++; $display("FAIL single_latency got %0d expected 12", done_t); end
`ifdef SAD_SEQ_PERF_CNT_EN
    n_tests++;
    if (if_a.perf_cycles !== 32'd13) begin
      n_fail++; $display("FAIL perf_cycles got %0d expected 13", if_a.perf_cycles);
    end
`endif
  endtask

  task automatic test_multi_column();
    snap_t o, e;
    logic [31:0] tags[$];
    logic [31:0] want[4];
    want[0] = 32'h400; want[1] = 32'h440; want[2] = 32'h404; want[3] = 32'h444;
    drive(1'b1, 1'b1, 32'h100, 32'h400);
    tick();
    drive(1'b1, 1'b0, 32'h100, 32'h400);
    for (int t = 1; t <= 20; t++) begin
      o = snap_b;
      e = expect_at(t, 5, 2, 32'h100, 32'h400);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL multi t=%0d got %h expected %h", t, o, e); end
      if (o.mi) tags.push_back(o.tag);
      tick();
    end
    n_tests++;
    if (tags.size() != 4) begin
      n_fail++; $display("FAIL multi_min_in_count got %0d expected 4", tags.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (tags[i] !== want[i]) begin
          n_fail++; $display("FAIL multi_tag%0d got %h expected %h", i, tags[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    snap_t o, e;
    drive(1'b0, 1'b1, 32'h100, 32'h400);
    tick();
    drive(1'b0, 1'b0, 32'h100, 32'h400);
    for (int t = 1; t <= 6; t++) begin
      o = snap_a;
      e = expect_at(t, 4, 1, 32'h100, 32'h400);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL midscan t=%0d got %h expected %h", t, o, e); end
      if (t < 6) tick();
    end
    // Second SCAN cycle: assert reset and check outputs clear at once.
    Reset = 1'b0;
    #1;
    n_tests++;
    if (snap_a !== '0) begin n_fail++; $display("FAIL midscan_reset_now got %h expected 0", snap_a); end
    tick();
    n_tests++;
    if (snap_a !== '0) begin n_fail++; $display("FAIL midscan_reset_hold got %h expected 0", snap_a); end
    Reset = 1'b1;
    drive(1'b0, 1'b1, 32'h100, 32'h400);
    tick();
    drive(1'b0, 1'b0, 32'h100, 32'h400);
    for (int t = 1; t <= 13; t++) begin
      o = snap_a;
      e = expect_at(t, 4, 1, 32'h100, 32'h400);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL restart t=%0d got %h expected %h", t, o, e); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    snap_t o, e;
    int tt;
    drive(1'b0, 1'b1, 32'h2000, 32'h3000);
    tick();
    for (int t = 1; t <= 27; t++) begin
      if (t == 20) drive(1'b0, 1'b0, 32'h2000, 32'h3000);
      // Second search starts from the IDLE cycle t=13.
      tt = (t <= 12) ? t : t - 13;
      o  = snap_a;
      e  = expect_at(tt, 4, 1, 32'h2000, 32'h3000);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back t=%0d got %h expected %h", t, o, e); end
      tick();
    end
  endtask

  task automatic test_random();
    snap_t o, e;
    bit sel;
    int rows, cols;
    logic [31:0] wb, fb;
    for (int n = 0; n < 6; n++) begin
      sel = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wb  = (n == 0) ? 32'hFFFF_FFC0 : $urandom;
      fb  = (n == 0) ? 32'hFFFF_FF40 : $urandom;
      rows = sel ? 5 : 4;
      cols = sel ? 2 : 1;
      drive(sel, 1'b1, wb, fb);
      tick();
      drive(sel, 1'b0, wb, fb);
      for (int t = 1; t <= 10 + rows * cols; t++) begin
        o = sel ? snap_b : snap_a;
        e = expect_at(t, rows, cols, wb, fb);
        n_tests++;
        if (o !== e) begin
          n_fail++; $display("FAIL random n=%0d t=%0d got %h expected %h", n, t, o, e);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_multi_column();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
